// File: rtl/sdram_arbiter_if.sv
// Command-bus bundle between the init/refresh/write/read sub-controllers and the arbiter,
// including the SDRAM control/address pins the arbiter drives.
interface sdram_arbiter_if #(
   parameter int ADDR_W = 13,
   parameter int DQ_W   = 16
);
   logic              init_end_i;
   logic [3:0]        init_cmd_i;
   logic [1:0]        init_ba_i;
   logic [ADDR_W-1:0] init_addr_i;

   logic              aref_req_i;
   logic              aref_end_i;
   logic [3:0]        aref_cmd_i;
   logic [1:0]        aref_ba_i;
   logic [ADDR_W-1:0] aref_addr_i;
   logic              aref_en_o;

   logic              wr_req_i;
   logic              wr_end_i;
   logic [3:0]        wr_cmd_i;
   logic [1:0]        wr_ba_i;
   logic [ADDR_W-1:0] wr_addr_i;
   logic              wr_sdram_en_i;
   logic [DQ_W-1:0]   wr_data_i;
   logic              wr_en_o;

   logic              rd_req_i;
   logic              rd_end_i;
   logic [3:0]        rd_cmd_i;
   logic [1:0]        rd_ba_i;
   logic [ADDR_W-1:0] rd_addr_i;
   logic              rd_en_o;

   logic              sdram_cke_o;
   logic              sdram_cs_n_o;
   logic              sdram_ras_n_o;
   logic              sdram_cas_n_o;
   logic              sdram_we_n_o;
   logic [1:0]        sdram_ba_o;
   logic [ADDR_W-1:0] sdram_addr_o;

   modport master (
      output init_end_i, init_cmd_i, init_ba_i, init_addr_i,
      output aref_req_i, aref_end_i, aref_cmd_i, aref_ba_i, aref_addr_i,
      output wr_req_i, wr_end_i, wr_cmd_i, wr_ba_i, wr_addr_i, wr_sdram_en_i, wr_data_i,
      output rd_req_i, rd_end_i, rd_cmd_i, rd_ba_i, rd_addr_i,
      input  aref_en_o, wr_en_o, rd_en_o,
      input  sdram_cke_o, sdram_cs_n_o, sdram_ras_n_o, sdram_cas_n_o, sdram_we_n_o,
      input  sdram_ba_o, sdram_addr_o
   );

   modport slave (
      input  init_end_i, init_cmd_i, init_ba_i, init_addr_i,
      input  aref_req_i, aref_end_i, aref_cmd_i, aref_ba_i, aref_addr_i,
      input  wr_req_i, wr_end_i, wr_cmd_i, wr_ba_i, wr_addr_i, wr_sdram_en_i, wr_data_i,
      input  rd_req_i, rd_end_i, rd_cmd_i, rd_ba_i, rd_addr_i,
      output aref_en_o, wr_en_o, rd_en_o,
      output sdram_cke_o, sdram_cs_n_o, sdram_ras_n_o, sdram_cas_n_o, sdram_we_n_o,
      output sdram_ba_o, sdram_addr_o
   );
endinterface

// File: rtl/sdram_arbiter.sv
// SDRAM command arbiter: refresh > write > read after init; zero-latency pin mux, grant held
// until the owner's end pulse. Define SDRAM_ARB_RR_EN for round-robin between write and read.
module sdram_arbiter #(
   parameter int DQ_W   = 16,
   parameter int ADDR_W = 13
) (
   input  logic            sys_clk_i,
   input  logic            rst_n_i,
   sdram_arbiter_if.slave  bus,
   inout  wire [DQ_W-1:0]  sdram_dq_io
);
   localparam logic [3:0] CMD_NOP = 4'b0111;

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_ARB   = 3'd1,
      ST_AREF  = 3'd2,
      ST_WRITE = 3'd3,
      ST_READ  = 3'd4
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              aref_pend;
   logic              aref_hit;
   logic              wr_wins;
   logic [3:0]        cmd;
   logic [1:0]        ba;
   logic [ADDR_W-1:0] addr;

   assign aref_hit = aref_pend | bus.aref_req_i;

`ifdef SDRAM_ARB_RR_EN
   state_t last_grant;

   always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         last_grant <= ST_READ;
      else if (state == ST_ARB && (state_nxt == ST_WRITE || state_nxt == ST_READ))
         last_grant <= state_nxt;
   end

   // On contention the side that did not win last time goes first.
   assign wr_wins = !(bus.rd_req_i && last_grant == ST_WRITE);
`else
   assign wr_wins = 1'b1;
`endif

   always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         state <= ST_INIT;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_INIT:  if (bus.init_end_i) state_nxt = ST_ARB;
         ST_ARB: begin
            if (aref_hit)
               state_nxt = ST_AREF;
            else if (bus.wr_req_i && wr_wins)
               state_nxt = ST_WRITE;
            else if (bus.rd_req_i)
               state_nxt = ST_READ;
         end
         ST_AREF:  if (bus.aref_end_i) state_nxt = ST_ARB;
         ST_WRITE: if (bus.wr_end_i)   state_nxt = ST_ARB;
         ST_READ:  if (bus.rd_end_i)   state_nxt = ST_ARB;
         default:  state_nxt = ST_INIT;
      endcase
   end

   // Refresh requests that land mid-burst wait here; repeats collapse into one.
   always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         aref_pend <= 1'b0;
      else if (state == ST_ARB && aref_hit)
         aref_pend <= 1'b0;
      else if (bus.aref_req_i && state != ST_INIT)
         aref_pend <= 1'b1;
   end

   always_comb begin
      cmd  = CMD_NOP;
      ba   = 2'b11;
      addr = '1;
      case (state)
         ST_INIT: begin
            cmd  = bus.init_cmd_i;
            ba   = bus.init_ba_i;
            addr = bus.init_addr_i;
         end
         ST_AREF: begin
            cmd  = bus.aref_cmd_i;
            ba   = bus.aref_ba_i;
            addr = bus.aref_addr_i;
         end
         ST_WRITE: begin
            cmd  = bus.wr_cmd_i;
            ba   = bus.wr_ba_i;
            addr = bus.wr_addr_i;
         end
         ST_READ: begin
            cmd  = bus.rd_cmd_i;
            ba   = bus.rd_ba_i;
            addr = bus.rd_addr_i;
         end
         default: ;
      endcase
   end

   assign bus.aref_en_o     = (state == ST_AREF);
   assign bus.wr_en_o       = (state == ST_WRITE);
   assign bus.rd_en_o       = (state == ST_READ);

   assign bus.sdram_cke_o   = 1'b1;
   assign bus.sdram_cs_n_o  = cmd[3];
   assign bus.sdram_ras_n_o = cmd[2];
   assign bus.sdram_cas_n_o = cmd[1];
   assign bus.sdram_we_n_o  = cmd[0];
   assign bus.sdram_ba_o    = ba;
   assign bus.sdram_addr_o  = addr;

   assign sdram_dq_io = (state == ST_WRITE && bus.wr_sdram_en_i) ? bus.wr_data_i : {DQ_W{1'bz}};
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Central command arbiter for the SDR SDRAM controller. Sits between the init, auto-refresh, write and read sub-controllers and the SDRAM pins.
- Holds off all traffic until initialisation completes. Afterwards it grants the command bus to exactly one sub-controller at a time: refresh first, then write, then read.
- Muxes the granted sub-controller's cmd/ba/addr onto the pins and drives the DQ tri-state.

Parameters:
- DQ_W, 16, SDRAM data bus width
- ADDR_W, 13, SDRAM address bus width (A12-A0)

Ports:
- sys_clk_i  in  1  100 MHz clock
- rst_n_i  in  1  reset, asynchronous, active-low
- init_end_i  in  1  init done, level, stays high once set
- init_cmd_i / init_ba_i / init_addr_i  in  4 / 2 / ADDR_W  init-phase command, bank, address
- aref_req_i  in  1  refresh request, one-cycle pulse every 7.5 us
- aref_end_i  in  1  refresh sequence done, one-cycle pulse
- aref_cmd_i / aref_ba_i / aref_addr_i  in  4 / 2 / ADDR_W  refresh command, bank, address
- aref_en_o  out  1  refresh grant
- wr_req_i  in  1  write request, level, held until granted
- wr_end_i  in  1  write burst done, one-cycle pulse
- wr_cmd_i / wr_ba_i / wr_addr_i  in  4 / 2 / ADDR_W  write command, bank, address
- wr_sdram_en_i  in  1  drive DQ this cycle
- wr_data_i  in  DQ_W  write data
- wr_en_o  out  1  write grant
- rd_req_i  in  1  read request, level, held until granted
- rd_end_i  in  1  read burst done, one-cycle pulse
- rd_cmd_i / rd_ba_i / rd_addr_i  in  4 / 2 / ADDR_W  read command, bank, address
- rd_en_o  out  1  read grant
- sdram_cke_o / sdram_cs_n_o / sdram_ras_n_o / sdram_cas_n_o / sdram_we_n_o  out  1 each  SDRAM control pins
- sdram_ba_o  out  2  SDRAM bank address
- sdram_addr_o  out  ADDR_W  SDRAM address
- sdram_dq_io  inout  DQ_W  SDRAM data bus

Behaviour:
- Command encoding: 4-bit {cs_n, ras_n, cas_n, we_n}, taken from the shared SDRAM defines file. NOP = 4'b0111.
- sdram_cke_o is tied to 1.
- State register (async reset to INIT). States:
  - INIT: go to ARB when init_end_i = 1.
  - ARB: choose the next state using arbitration priority.
  - AREF: go to ARB on aref_end_i.
  - WRITE: go to ARB on wr_end_i.
  - READ: go to ARB on rd_end_i.
- Arbitration in ARB:
  - aref_hit = aref_pend | aref_req_i.
  - aref_hit → AREF; else wr_req_i → WRITE; else rd_req_i → READ; else stay in ARB.
- aref_pend flag:
  - Reset value 0.
  - Set on aref_req_i in any state except INIT; pulses during INIT are dropped.
  - Cleared on the ARB→AREF transition.
  - A second pulse while already pending is absorbed; there is no counting.
- Grants are combinational decodes of state: aref_en_o = (state==AREF), wr_en_o = (state==WRITE), rd_en_o = (state==READ).
  - Each grant drops in the cycle after the matching *_end pulse.
  - The grant is one-hot, or all grants are low.
- Pin mux (combinational, zero latency):
  - INIT → init_*.
  - AREF → aref_*.
  - WRITE → wr_*.
  - READ → rd_*.
  - ARB → NOP, ba 2'b11, addr all ones.
- Values during reset: state = INIT, so pins follow init_*; all grants 0; aref_pend 0; DQ high-Z.
- Refresh pulse arriving during WRITE/READ: latched; the current burst is not aborted; the refresh is serviced on the return to ARB.
  - Worst-case added refresh latency = one burst + 1 cycle.
- *_end pulse arriving in a non-matching state: ignored.
- DQ: driven with wr_data_i only when state==WRITE and wr_sdram_en_i = 1; otherwise high-Z.
- Reset mid-operation: immediate return to INIT; grants drop asynchronously; DQ goes high-Z.

Optional Feature:
- Macro: SDRAM_ARB_RR_EN.
- When defined:
  - A last_grant register records the most recent WRITE/READ grant; reset value = READ.
  - In ARB, with no refresh pending and both wr_req_i and rd_req_i high, the requester not granted last wins.
  - Refresh still has absolute priority.
- When undefined: fixed priority, write over read. No last_grant register is built.

Test Plan:
- Hold init_end_i = 0 for 20 cycles with init_cmd_i = 4'b0010 → pins show 0010 and all grants 0. Raise init_end_i → state ARB next cycle, pins show NOP with addr 13'h1FFF.
- In ARB, pulse aref_req_i with wr_req_i = 1 in the same cycle → aref_en_o = 1 the next cycle and wr_en_o stays 0. Pulse aref_end_i → one ARB cycle, then wr_en_o = 1.
- During WRITE, pulse aref_req_i twice, then pulse wr_end_i → exactly one AREF grant follows, and aref_pend = 0 after the AREF entry.
- In WRITE, drive wr_sdram_en_i = 1 with wr_data_i = 16'hA55A → sdram_dq_io = A55A. Drop wr_sdram_en_i → DQ = Z. In READ, DQ = Z.
- Hold wr_req_i = rd_req_i = 1 continuously → without the macro, only WRITE is granted. With SDRAM_ARB_RR_EN, grants alternate WRITE, READ, WRITE.
- Assert reset mid-READ → rd_en_o = 0 immediately, pins follow init_*, DQ = Z.
